// File: rtl/fd_pkg.sv
// Shared definitions for the fetch->decode pipe buffer: NOP encoding,
// a constant log2 helper and the default fetch entry layout.
package fd_pkg;

  // addi x0, x0, 0 -- the architectural NOP decode sees when the buffer is empty
  localparam logic [31:0] NOP_ADDI = 32'h0000_0013;

  // Default field widths of a fetched instruction entry
  localparam int FD_PC_W   = 16;
  localparam int FD_INST_W = 32;

  // One fetched instruction as it crosses the fetch->decode boundary
  typedef struct packed {
    logic [FD_PC_W-1:0]   pc;
    logic [FD_INST_W-1:0] inst;
  } fd_entry_t;

  // Ceiling log2 usable in constant expressions; returns at least 1
  function automatic int fd_clog2(input int value);
    int result;
    int limit;
    result = 1;
    limit  = 2;
    while (limit < value) begin
      result = result + 1;
      limit  = limit * 2;
    end
    return result;
  endfunction

endpackage

// File: rtl/fd_pipe_buffer_sat_counter.sv
// Saturating up-counter: increments by one on inc_i, sticks at all-ones,
// cleared asynchronously by clr_i.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step by one unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous clear
  always_ff @(posedge clk or posedge clr_i) begin
    if (clr_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fd_pipe_buffer.sv
// Fetch->decode boundary buffer: a DEPTH-entry flop FIFO with valid/ready
// on both sides, whole-buffer flush on a taken jump/branch, NOP presentation
// when empty, and saturating stall/bubble/flush cycle counters.
module fd_pipe_buffer
  import fd_pkg::*;
#(
  parameter int                PC_W   = FD_PC_W,
  parameter int                INST_W = FD_INST_W,
  parameter int                DEPTH  = 2,
  parameter logic [INST_W-1:0] NOP    = INST_W'(NOP_ADDI),
  parameter int                CNT_W  = 16,
  localparam int               LVL_W  = fd_clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              flush,
  output logic [LVL_W-1:0]  level,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int               PTR_W    = fd_clog2(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Storage is never reset; entries are only readable while counted in level
  logic [PC_W-1:0]   mem_pc_q   [DEPTH];
  logic [INST_W-1:0] mem_inst_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;

  assign full_s  = (level_q == LVL_FULL);
  assign empty_s = (level_q == {LVL_W{1'b0}});

  // A flush drops the same-cycle offer; a pop is still honoured
  assign push_s = in_valid & ~full_s & ~flush;
  assign pop_s  = ~empty_s & out_ready;

  // Next-state for pointers, occupancy and the last popped PC
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    last_pc_d = last_pc_q;

    if (pop_s) begin
      last_pc_d = mem_pc_q[rd_ptr_q];
    end else begin
      last_pc_d = last_pc_q;
    end

    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      level_d  = {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Control state registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      level_q   <= {LVL_W{1'b0}};
      last_pc_q <= {PC_W{1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      last_pc_q <= last_pc_d;
    end
  end

  // Entry storage write on an accepted push
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_pc_q[wr_ptr_q]   <= in_pc;
      mem_inst_q[wr_ptr_q] <= in_inst;
    end
  end

  // Head presentation: real entry when valid, otherwise NOP at the last popped PC
  always_comb begin
    out_pc   = last_pc_q;
    out_inst = NOP;
    if (!empty_s) begin
      out_pc   = mem_pc_q[rd_ptr_q];
      out_inst = mem_inst_q[rd_ptr_q];
    end else begin
      out_pc   = last_pc_q;
      out_inst = NOP;
    end
  end

  assign in_ready  = ~full_s;
  assign out_valid = ~empty_s;
  assign level     = level_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (~empty_s & ~out_ready),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (empty_s),
    .cnt_o (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (flush),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_fd_pipe_buffer.sv
// Directed bench for fd_pipe_buffer (DEPTH=2, CNT_W=4 so saturation is reachable).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fd_pipe_buffer;

  localparam int          PC_W   = 16;
  localparam int          INST_W = 32;
  localparam int          DEPTH  = 2;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] NOPV   = 32'h0000_0013;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              flush;
  logic [1:0]        level;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int tests_run;
  int tests_failed;

  fd_pipe_buffer #(
    .PC_W  (PC_W),
    .INST_W(INST_W),
    .DEPTH (DEPTH),
    .NOP   (NOPV),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .flush     (flush),
    .level     (level),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic [15:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pc     = 16'h0000;
    in_inst   = 32'h0000_0000;
    out_ready = 1'b0;
    flush     = 1'b0;

    // 1. reset, then three idle cycles
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t1_out_valid", 32'(out_valid), 32'd0);
    check_eq("t1_out_inst", out_inst, NOPV);
    check_eq("t1_out_pc", 32'(out_pc), 32'h0000_0000);
    check_eq("t1_in_ready", 32'(in_ready), 32'd1);
    check_eq("t1_level", 32'(level), 32'd0);
    check_eq("t1_bubble", 32'(bubble_cnt), 32'd3);

    // 2. single push, seen next cycle, popped, then NOP at last PC
    out_ready = 1'b1;
    offer(16'h0004, 32'h0050_0093);
    check_eq("t2_no_bypass", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("t2_valid", 32'(out_valid), 32'd1);
    check_eq("t2_pc", 32'(out_pc), 32'h0000_0004);
    check_eq("t2_inst", out_inst, 32'h0050_0093);
    @(negedge clk);
    check_eq("t2_empty", 32'(out_valid), 32'd0);
    check_eq("t2_last_pc", 32'(out_pc), 32'h0000_0004);
    check_eq("t2_nop", out_inst, NOPV);
    check_eq("t2_bubble", 32'(bubble_cnt), 32'd4);

    // 3. stall decode, fill, third offer held, release in order
    out_ready = 1'b0;
    offer(16'h0008, 32'h1111_1111);
    @(negedge clk);
    offer(16'h000C, 32'h2222_2222);
    @(negedge clk);
    check_eq("t3_level_full", 32'(level), 32'd2);
    check_eq("t3_in_ready", 32'(in_ready), 32'd0);
    check_eq("t3_stall1", 32'(stall_cnt), 32'd1);
    check_eq("t3_bubble", 32'(bubble_cnt), 32'd5);
    offer(16'h0010, 32'h3333_3333);
    @(negedge clk);
    check_eq("t3_stall2", 32'(stall_cnt), 32'd2);
    check_eq("t3_head_a", 32'(out_pc), 32'h0000_0008);
    out_ready = 1'b1;
    check_eq("t3_full_no_bypass", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_eq("t3_level_after_pop", 32'(level), 32'd1);
    check_eq("t3_head_b", out_inst, 32'h2222_2222);
    check_eq("t3_stall_hold", 32'(stall_cnt), 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("t3_level_pushpop", 32'(level), 32'd1);
    check_eq("t3_head_c", out_inst, 32'h3333_3333);
    @(negedge clk);
    check_eq("t3_drained", 32'(out_valid), 32'd0);
    check_eq("t3_last_pc", 32'(out_pc), 32'h0000_0010);

    // 4. flush while full drops contents and the same-cycle offer
    out_ready = 1'b0;
    offer(16'h0020, 32'h5555_5555);
    @(negedge clk);
    offer(16'h0024, 32'h6666_6666);
    @(negedge clk);
    check_eq("t4_full", 32'(level), 32'd2);
    flush = 1'b1;
    offer(16'h0028, 32'h7777_7777);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("t4_level0", 32'(level), 32'd0);
    check_eq("t4_nop", out_inst, NOPV);
    check_eq("t4_pc_kept", 32'(out_pc), 32'h0000_0010);
    check_eq("t4_flush_cnt", 32'(flush_cnt), 32'd1);
    check_eq("t4_stall", 32'(stall_cnt), 32'd4);
    @(negedge clk);
    check_eq("t4_not_stored", 32'(level), 32'd0);
    offer(16'h0030, 32'h8888_8888);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    check_eq("t4_g_head", 32'(out_pc), 32'h0000_0030);
    @(negedge clk);
    flush = 1'b0;
    check_eq("t4_pop_on_flush_pc", 32'(out_pc), 32'h0000_0030);
    check_eq("t4_pop_on_flush_lvl", 32'(level), 32'd0);
    check_eq("t4_flush_cnt2", 32'(flush_cnt), 32'd2);

    // 5. stall counter saturates at 15 with CNT_W=4
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    offer(16'h0050, 32'h9999_9999);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t5_stall_sat", 32'(stall_cnt), 32'd15);
    check_eq("t5_level", 32'(level), 32'd1);

    // 6. asynchronous reset mid-transfer clears immediately
    rst = 1'b1;
    #1;
    check_eq("t6_valid", 32'(out_valid), 32'd0);
    check_eq("t6_inst", out_inst, NOPV);
    check_eq("t6_pc", 32'(out_pc), 32'h0000_0000);
    check_eq("t6_level", 32'(level), 32'd0);
    check_eq("t6_in_ready", 32'(in_ready), 32'd1);
    check_eq("t6_stall", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    offer(16'h0040, 32'h4444_4444);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("t6_first_push", 32'(out_valid), 32'd1);
    check_eq("t6_first_pc", 32'(out_pc), 32'h0000_0040);
    check_eq("t6_first_inst", out_inst, 32'h4444_4444);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
